// File: rtl/ffnn_pkg.sv
// ffnn_pkg: shared encodings, FSM states and
// elaboration helpers for the layer engine.
package ffnn_pkg;

  localparam logic [1:0] TERN_POS  = 2'b01;
  localparam logic [1:0] TERN_NEG  = 2'b11;
  localparam logic [1:0] TERN_ZERO = 2'b00;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/ffnn_ternary_act.sv
// ffnn_ternary_act: symmetric threshold compare
// mapping a signed sum onto {+1, 0, -1}.
module ffnn_ternary_act
  import ffnn_pkg::*;
#(
  parameter int ACCW = 19,
  parameter int THR  = 1
) (
  input  logic signed [ACCW-1:0] z,
  output logic        [1:0]      y
);

  localparam logic signed [ACCW-1:0] TP = ACCW'(THR);
  localparam logic signed [ACCW-1:0] TN = -TP;

  always_comb begin
    unique case (1'b1)
      (z > TP): y = TERN_POS;
      (z < TN): y = TERN_NEG;
      default:  y = TERN_ZERO;
    endcase
  end

endmodule

// File: rtl/ffnn_layer_engine.sv
// ffnn_layer_engine: one fully-connected layer,
// one MAC per cycle, ternary activation per neuron.
module ffnn_layer_engine
  import ffnn_pkg::*;
#(
  parameter  int N_IN  = 4,
  parameter  int N_OUT = 6,
  parameter  int XW    = 9,
  parameter  int WW    = 8,
  parameter  int THR   = 1,
  localparam int ACCW  = XW + WW + clog2(N_IN),
  localparam int NW    = N_IN * N_OUT,
  localparam int AW    = (clog2(NW) > 0) ? clog2(NW) : 1
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic signed [WW-1:0]    wr_data,
  output logic                    wr_err,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_IN*XW-1:0]      in_x,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N_OUT*2-1:0]      out_y,
  output logic                    busy
);

  localparam int PW = XW + WW;
  localparam int IW = (clog2(N_IN) > 0) ? clog2(N_IN) : 1;
  localparam int JW = (clog2(N_OUT) > 0) ? clog2(N_OUT) : 1;

  state_t state, state_nx;

  logic                       rst_done;
  logic [N_IN-1:0][XW-1:0]    x_q;
  logic signed [WW-1:0]       w_q [NW];
  logic [IW-1:0]              i_q;
  logic [JW-1:0]              j_q;
  logic [AW-1:0]              k_q;
  logic signed [ACCW-1:0]     acc_q;
  logic signed [ACCW-1:0]     z;
  logic signed [PW-1:0]       prod;
  logic [N_OUT-1:0][1:0]      y_q;
  logic [1:0]                 y_act;
  logic accept, last_i, last_j;
  logic in_range, wr_bad, wr_ok;

  assign in_range = {1'b0, wr_addr} < (AW+1)'(NW);
  assign wr_bad   = wr_en & ((state == MAC) | ~in_range);
  assign wr_ok    = wr_en & ~wr_bad;
  assign accept   = in_valid & in_ready;
  assign last_i   = (i_q == IW'(N_IN - 1));
  assign last_j   = (j_q == JW'(N_OUT - 1));

  // k_q walks the flat weight index j*N_IN+i
  assign prod = PW'($signed(x_q[i_q])) * PW'(w_q[k_q]);
  assign z    = acc_q + ACCW'(prod);
  assign out_y = y_q;

  ffnn_ternary_act #(
    .ACCW (ACCW),
    .THR  (THR)
  ) u_act (
    .z (z),
    .y (y_act)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = MAC;
      MAC:     if (last_i && last_j) state_nx = OUT;
      OUT:     if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) & rst_done;
    busy      = (state == MAC);
    out_valid = (state == OUT);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rst_done <= 1'b0;
      wr_err   <= 1'b0;
      x_q      <= '0;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      y_q      <= '0;
      for (int n = 0; n < NW; n++) w_q[n] <= '0;
    end else begin
      rst_done <= 1'b1;
      wr_err   <= wr_bad;
      if (wr_ok) w_q[wr_addr] <= wr_data;
      if (state == IDLE && accept) begin
        x_q   <= in_x;
        i_q   <= '0;
        j_q   <= '0;
        k_q   <= '0;
        acc_q <= '0;
      end else if (state == MAC) begin
        k_q <= k_q + 1'b1;
        if (last_i) begin
          y_q[j_q] <= y_act;
          acc_q    <= '0;
          i_q      <= '0;
          j_q      <= last_j ? '0 : j_q + 1'b1;
        end else begin
          acc_q <= z;
          i_q   <= i_q + 1'b1;
        end
      end
    end
  end

endmodule
